// File: rtl/mem_map_pkg.sv
// Shared memory map for the CPU bus controller: region and FSM enums,
// address window constants and the address decode helpers.
package mem_map_pkg;

   typedef enum logic [1:0] {
      REG_RAM = 2'd0,
      REG_IO  = 2'd1,
      REG_ROM = 2'd2
   } region_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int WAIT_W = 3;

   localparam logic [15:0] RAM_BASE  = 16'h0000;
   localparam logic [15:0] RAM_LIMIT = 16'h5FFF;
   localparam logic [15:0] IO_BASE   = 16'h6000;
   localparam logic [15:0] IO_LIMIT  = 16'h7FFF;
   localparam logic [15:0] ROM_BASE  = 16'h8000;
   localparam logic [15:0] ROM_LIMIT = 16'hFFFF;

   function automatic logic in_range(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
      return (addr >= base) && (addr <= limit);
   endfunction

   // Any address outside the IO and ROM windows lands in RAM.
   function automatic region_t decode_region(input logic [15:0] addr);
      region_t region;
      region = REG_RAM;
      if (in_range(addr, ROM_BASE, ROM_LIMIT)) begin
         region = REG_ROM;
      end else if (in_range(addr, IO_BASE, IO_LIMIT)) begin
         region = REG_IO;
      end else if (in_range(addr, RAM_BASE, RAM_LIMIT)) begin
         region = REG_RAM;
      end
      return region;
   endfunction

   function automatic logic [WAIT_W-1:0] region_wait(input region_t region,
                                                     input logic [WAIT_W-1:0] romWait,
                                                     input logic [WAIT_W-1:0] ramWait,
                                                     input logic [WAIT_W-1:0] ioWait);
      logic [WAIT_W-1:0] waitValue;
      case (region)
         REG_ROM: waitValue = romWait;
         REG_IO:  waitValue = ioWait;
         default: waitValue = ramWait;
      endcase
      return waitValue;
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: loaded when an access is accepted, counts down
// once per ACCESS cycle and flags zero on the final ACCESS cycle.
module wait_counter
   import mem_map_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [WAIT_W-1:0] i_loadValue,
   input  logic              i_dec,
   output logic              o_zero
);

   logic [WAIT_W-1:0] r_count;

   // Load wins over decrement; the count saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory bus controller: decodes a latched CPU address to RAM, IO or
// ROM, inserts per-region wait states and returns a one-cycle ack.
module mem_bus_ctrl
   import mem_map_pkg::*;
#(
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 0,
   parameter int IO_WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   output logic        rom_oe,
   output logic [14:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        ram_cs,
   output logic        ram_we,
   output logic [14:0] ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic        io_cs,
   output logic        io_we,
   output logic [3:0]  io_addr,
   output logic [7:0]  io_wdata,
   input  logic [7:0]  io_rdata,
   output logic        rom_wr_err
);

   localparam logic [WAIT_W-1:0] ROM_WAIT_C = WAIT_W'(ROM_WAIT);
   localparam logic [WAIT_W-1:0] RAM_WAIT_C = WAIT_W'(RAM_WAIT);
   localparam logic [WAIT_W-1:0] IO_WAIT_C  = WAIT_W'(IO_WAIT);

   state_t            r_state;
   state_t            w_nextState;
   logic [15:0]       r_addr;
   logic              r_rw;
   logic [7:0]        r_wdata;
   logic [7:0]        r_rdata;
   logic              r_romWrErr;
   region_t           w_reqRegion;
   region_t           w_curRegion;
   logic              w_accept;
   logic              w_waitZero;
   logic              w_finalCycle;
   logic [WAIT_W-1:0] w_loadValue;
   logic [7:0]        w_rdMux;

   assign w_reqRegion  = decode_region(cpu_addr);
   assign w_curRegion  = decode_region(r_addr);
   assign w_accept     = (r_state == ST_IDLE) && cpu_req;
   assign w_finalCycle = (r_state == ST_ACCESS) && w_waitZero;
   assign w_loadValue  = region_wait(w_reqRegion, ROM_WAIT_C, RAM_WAIT_C, IO_WAIT_C);

   wait_counter u_waitCounter (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_accept),
      .i_loadValue (w_loadValue),
      .i_dec       (r_state == ST_ACCESS),
      .o_zero      (w_waitZero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Requests are only looked at in IDLE, so anything arriving later is dropped.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:   if (cpu_req) w_nextState = ST_ACCESS;
         ST_ACCESS: if (w_waitZero) w_nextState = ST_DONE;
         ST_DONE:   w_nextState = ST_IDLE;
         default:   w_nextState = ST_IDLE;
      endcase
   end

   // A ROM write still runs through ACCESS for timing, just with rom_oe held low.
   always_comb begin
      cpu_ack = 1'b0;
      rom_oe  = 1'b0;
      ram_cs  = 1'b0;
      ram_we  = 1'b0;
      io_cs   = 1'b0;
      io_we   = 1'b0;
      case (r_state)
         ST_ACCESS: begin
            rom_oe = (w_curRegion == REG_ROM) && r_rw;
            ram_cs = (w_curRegion == REG_RAM);
            io_cs  = (w_curRegion == REG_IO);
            ram_we = (w_curRegion == REG_RAM) && !r_rw && w_waitZero;
            io_we  = (w_curRegion == REG_IO) && !r_rw && w_waitZero;
         end
         ST_DONE: cpu_ack = 1'b1;
         default: cpu_ack = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr  <= '0;
         r_rw    <= 1'b0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_addr  <= cpu_addr;
         r_rw    <= cpu_rw;
         r_wdata <= cpu_wdata;
      end
   end

   always_comb begin
      case (w_curRegion)
         REG_ROM: w_rdMux = rom_data;
         REG_IO:  w_rdMux = io_rdata;
         default: w_rdMux = ram_rdata;
      endcase
   end

   // Read data is captured once, on the last ACCESS cycle, and held across writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (w_finalCycle && r_rw) begin
         r_rdata <= w_rdMux;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_romWrErr <= 1'b0;
      end else if (w_accept && !cpu_rw && (w_reqRegion == REG_ROM)) begin
         r_romWrErr <= 1'b1;
      end
   end

   // The ROM is 8 KiB, so the upper address bits are dropped to mirror it.
   assign rom_addr   = {2'b00, r_addr[12:0]};
   assign ram_addr   = r_addr[14:0];
   assign io_addr    = r_addr[3:0];
   assign ram_wdata  = r_wdata;
   assign io_wdata   = r_wdata;
   assign cpu_rdata  = r_rdata;
   assign rom_wr_err = r_romWrErr;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with default wait states (ROM 1, RAM 0, IO 2).
module tb_mem_bus_ctrl;
   import mem_map_pkg::*;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        rom_oe;
   logic [14:0] rom_addr;
   logic [7:0]  romVal;
   wire  [7:0]  romData;
   logic        ram_cs;
   logic        ram_we;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ramRdata;
   logic        io_cs;
   logic        io_we;
   logic [3:0]  io_addr;
   logic [7:0]  io_wdata;
   logic [7:0]  ioRdata;
   logic        rom_wr_err;

   int testsRun;
   int testsFailed;

   assign romData = rom_oe ? romVal : 8'hzz;

   mem_bus_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_rw     (cpu_rw),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .rom_oe     (rom_oe),
      .rom_addr   (rom_addr),
      .rom_data   (romData),
      .ram_cs     (ram_cs),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ramRdata),
      .io_cs      (io_cs),
      .io_we      (io_we),
      .io_addr    (io_addr),
      .io_wdata   (io_wdata),
      .io_rdata   (ioRdata),
      .rom_wr_err (rom_wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Presents a request just before the next rising edge; cycle 1 follows that edge.
   task automatic applyStimulus(input logic [15:0] addr, input logic rw, input logic [7:0] wdata);
      cpu_addr  = addr;
      cpu_rw    = rw;
      cpu_wdata = wdata;
      cpu_req   = 1'b1;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      cpu_req  = 1'b1;
      cpu_addr = 16'h1000;
      cpu_rw   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      testsRun++;
      if (ram_cs !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_priority_cs: got %b expected 0", ram_cs);
      end
      testsRun++;
      if (dut.r_state !== ST_IDLE) begin
         testsFailed++;
         $display("[TB] FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE);
      end
      testsRun++;
      if (cpu_ack !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_ack: got %b expected 0", cpu_ack);
      end
      testsRun++;
      if (cpu_rdata !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset_rdata: got %h expected 00", cpu_rdata);
      end
      testsRun++;
      if (rom_wr_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_wr_err: got %b expected 0", rom_wr_err);
      end
      cpu_req = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ram_read();
      int csCycles = 0;
      int ackCycle = -1;
      logic [14:0] seenAddr = '0;
      ramRdata = 8'h5A;
      applyStimulus(16'h0042, 1'b1, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
         if (ram_cs) begin
            csCycles++;
            seenAddr = ram_addr;
         end
         if (cpu_ack && ackCycle < 0) ackCycle = c;
      end
      testsRun++;
      if (csCycles != 1) begin
         testsFailed++;
         $display("[TB] FAIL ram_read_cs_cycles: got %0d expected 1", csCycles);
      end
      testsRun++;
      if (seenAddr !== 15'h0042) begin
         testsFailed++;
         $display("[TB] FAIL ram_read_addr: got %h expected 0042", seenAddr);
      end
      testsRun++;
      if (ackCycle != 2) begin
         testsFailed++;
         $display("[TB] FAIL ram_read_ack_cycle: got %0d expected 2", ackCycle);
      end
      testsRun++;
      if (cpu_rdata !== 8'h5A) begin
         testsFailed++;
         $display("[TB] FAIL ram_read_rdata: got %h expected 5a", cpu_rdata);
      end
   endtask

   task automatic test_rom_read();
      int oeCycles = 0;
      int ackCycle = -1;
      int ackCount = 0;
      logic [14:0] seenAddr = '0;
      logic [7:0] rdataAtAck = 8'hFF;
      romVal = 8'h00;
      applyStimulus(16'hFFFC, 1'b1, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
         if (rom_oe) begin
            oeCycles++;
            seenAddr = rom_addr;
         end
         if (cpu_ack) begin
            ackCount++;
            rdataAtAck = cpu_rdata;
            if (ackCycle < 0) ackCycle = c;
         end
      end
      testsRun++;
      if (oeCycles != 2) begin
         testsFailed++;
         $display("[TB] FAIL rom_read_oe_cycles: got %0d expected 2", oeCycles);
      end
      testsRun++;
      if (seenAddr !== 15'h1FFC) begin
         testsFailed++;
         $display("[TB] FAIL rom_read_mirror_addr: got %h expected 1ffc", seenAddr);
      end
      testsRun++;
      if (ackCycle != 3 || ackCount != 1) begin
         testsFailed++;
         $display("[TB] FAIL rom_read_ack: got cycle %0d count %0d expected cycle 3 count 1", ackCycle, ackCount);
      end
      testsRun++;
      if (rdataAtAck !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL rom_read_rdata: got %h expected 00", rdataAtAck);
      end
   endtask

   task automatic test_io_read();
      int csCycles = 0;
      int otherSel = 0;
      int ackCycle = -1;
      logic [3:0] seenAddr = '0;
      ioRdata = 8'hC3;
      applyStimulus(16'h7FF3, 1'b1, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
         if (io_cs) begin
            csCycles++;
            seenAddr = io_addr;
         end
         if (rom_oe || ram_cs) otherSel++;
         if (cpu_ack && ackCycle < 0) ackCycle = c;
      end
      testsRun++;
      if (csCycles != 3) begin
         testsFailed++;
         $display("[TB] FAIL io_read_cs_cycles: got %0d expected 3", csCycles);
      end
      testsRun++;
      if (seenAddr !== 4'h3) begin
         testsFailed++;
         $display("[TB] FAIL io_read_addr: got %h expected 3", seenAddr);
      end
      testsRun++;
      if (otherSel != 0) begin
         testsFailed++;
         $display("[TB] FAIL io_read_other_selects: got %0d expected 0", otherSel);
      end
      testsRun++;
      if (ackCycle != 4) begin
         testsFailed++;
         $display("[TB] FAIL io_read_ack_cycle: got %0d expected 4", ackCycle);
      end
      testsRun++;
      if (cpu_rdata !== 8'hC3) begin
         testsFailed++;
         $display("[TB] FAIL io_read_rdata: got %h expected c3", cpu_rdata);
      end
   endtask

   task automatic test_ram_write();
      int csCycle = -1;
      int weCycle = -1;
      int weCount = 0;
      int ackCycle = -1;
      logic [7:0] seenData = '0;
      logic [14:0] seenAddr = '0;
      applyStimulus(16'h1234, 1'b0, 8'hA5);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
         if (ram_cs && csCycle < 0) begin
            csCycle = c;
            seenData = ram_wdata;
            seenAddr = ram_addr;
         end
         if (ram_we) begin
            weCount++;
            weCycle = c;
         end
         if (cpu_ack && ackCycle < 0) ackCycle = c;
      end
      testsRun++;
      if (csCycle != 1 || weCycle != 1 || weCount != 1) begin
         testsFailed++;
         $display("[TB] FAIL ram_write_strobe: got cs %0d we %0d count %0d expected 1 1 1", csCycle, weCycle, weCount);
      end
      testsRun++;
      if (seenData !== 8'hA5 || seenAddr !== 15'h1234) begin
         testsFailed++;
         $display("[TB] FAIL ram_write_bus: got %h@%h expected a5@1234", seenData, seenAddr);
      end
      testsRun++;
      if (ackCycle != 2) begin
         testsFailed++;
         $display("[TB] FAIL ram_write_ack_cycle: got %0d expected 2", ackCycle);
      end
      testsRun++;
      if (cpu_rdata !== 8'hC3) begin
         testsFailed++;
         $display("[TB] FAIL ram_write_rdata_hold: got %h expected c3", cpu_rdata);
      end
   endtask

   task automatic test_io_write();
      int weCycle = -1;
      int weCount = 0;
      int ackCycle = -1;
      logic [7:0] seenData = '0;
      logic [3:0] seenAddr = '0;
      applyStimulus(16'h6005, 1'b0, 8'h3C);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
         if (io_we) begin
            weCount++;
            weCycle = c;
            seenData = io_wdata;
            seenAddr = io_addr;
         end
         if (cpu_ack && ackCycle < 0) ackCycle = c;
      end
      testsRun++;
      if (weCycle != 3 || weCount != 1) begin
         testsFailed++;
         $display("[TB] FAIL io_write_we: got cycle %0d count %0d expected cycle 3 count 1", weCycle, weCount);
      end
      testsRun++;
      if (seenData !== 8'h3C || seenAddr !== 4'h5) begin
         testsFailed++;
         $display("[TB] FAIL io_write_bus: got %h@%h expected 3c@5", seenData, seenAddr);
      end
      testsRun++;
      if (ackCycle != 4 || cpu_rdata !== 8'hC3) begin
         testsFailed++;
         $display("[TB] FAIL io_write_ack: got cycle %0d rdata %h expected 4 c3", ackCycle, cpu_rdata);
      end
   endtask

   task automatic test_rom_write();
      int oeCycles = 0;
      int ackCycle = -1;
      int ackCount = 0;
      applyStimulus(16'h9000, 1'b0, 8'h55);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
         if (rom_oe || ram_we || io_we) oeCycles++;
         if (cpu_ack) begin
            ackCount++;
            if (ackCycle < 0) ackCycle = c;
         end
      end
      testsRun++;
      if (oeCycles != 0) begin
         testsFailed++;
         $display("[TB] FAIL rom_write_oe: got %0d strobe cycles expected 0", oeCycles);
      end
      testsRun++;
      if (ackCycle != 3 || ackCount != 1) begin
         testsFailed++;
         $display("[TB] FAIL rom_write_ack: got cycle %0d count %0d expected cycle 3 count 1", ackCycle, ackCount);
      end
      testsRun++;
      if (rom_wr_err !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL rom_write_err: got %b expected 1", rom_wr_err);
      end
      ramRdata = 8'h66;
      applyStimulus(16'h0010, 1'b1, 8'h00);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) cpu_req = 1'b0;
      end
      testsRun++;
      if (rom_wr_err !== 1'b1 || cpu_rdata !== 8'h66) begin
         testsFailed++;
         $display("[TB] FAIL rom_write_err_sticky: got err %b rdata %h expected 1 66", rom_wr_err, cpu_rdata);
      end
   endtask

   task automatic test_reset_mid_access();
      int lateEvents = 0;
      ioRdata = 8'h77;
      applyStimulus(16'h6000, 1'b1, 8'h00);
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      testsRun++;
      if (io_cs !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_precondition: got io_cs %b expected 1", io_cs);
      end
      reset = 1'b1;
      @(negedge clk);
      testsRun++;
      if (io_cs !== 1'b0 || ram_cs !== 1'b0 || rom_oe !== 1'b0 || cpu_ack !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_outputs: got io %b ram %b rom %b ack %b expected 0 0 0 0", io_cs, ram_cs, rom_oe, cpu_ack);
      end
      testsRun++;
      if (dut.r_state !== ST_IDLE) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_state: got %0d expected %0d", dut.r_state, ST_IDLE);
      end
      testsRun++;
      if (cpu_rdata !== 8'h00 || rom_wr_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_regs: got rdata %h err %b expected 00 0", cpu_rdata, rom_wr_err);
      end
      reset = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (cpu_ack || io_cs || io_we) lateEvents++;
      end
      testsRun++;
      if (lateEvents != 0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_no_ack: got %0d events expected 0", lateEvents);
      end
   endtask

   task automatic test_back_to_back();
      int ackCount = 0;
      int csCount = 0;
      int consecutive = 0;
      int badGap = 0;
      int lastAck = -1;
      int firstAck = -1;
      logic prevAck = 1'b0;
      ramRdata = 8'h11;
      applyStimulus(16'h0100, 1'b1, 8'h00);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ram_cs) csCount++;
         if (cpu_ack) begin
            ackCount++;
            if (prevAck) consecutive++;
            if (lastAck >= 0 && (c - lastAck) != 3) badGap++;
            if (firstAck < 0) firstAck = c;
            lastAck = c;
         end
         prevAck = cpu_ack;
      end
      cpu_req = 1'b0;
      repeat (6) @(negedge clk);
      testsRun++;
      if (ackCount != 7 || csCount != 7) begin
         testsFailed++;
         $display("[TB] FAIL b2b_counts: got ack %0d cs %0d expected 7 7", ackCount, csCount);
      end
      testsRun++;
      if (consecutive != 0 || badGap != 0 || firstAck != 2) begin
         testsFailed++;
         $display("[TB] FAIL b2b_spacing: got consec %0d badgap %0d first %0d expected 0 0 2", consecutive, badGap, firstAck);
      end
      testsRun++;
      if (cpu_rdata !== 8'h11) begin
         testsFailed++;
         $display("[TB] FAIL b2b_rdata: got %h expected 11", cpu_rdata);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      cpu_req     = 1'b0;
      cpu_addr    = '0;
      cpu_rw      = 1'b1;
      cpu_wdata   = '0;
      romVal      = '0;
      ramRdata    = '0;
      ioRdata     = '0;
      @(negedge clk);
      test_reset();
      test_ram_read();
      test_rom_read();
      test_io_read();
      test_ram_write();
      test_io_write();
      test_rom_write();
      test_reset_mid_access();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 1, extra wait cycles for ROM accesses (0..7).
REQ-002 SHALL have parameter RAM_WAIT, default 0, extra wait cycles for RAM accesses (0..7).
REQ-003 SHALL have parameter IO_WAIT, default 2, extra wait cycles for IO accesses (0..7).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  access request, sampled only in IDLE.
REQ-007 cpu_addr  input  16  CPU byte address, latched on acceptance.
REQ-008 cpu_rw  input  1  1 = read, 0 = write, latched on acceptance.
REQ-009 cpu_wdata  input  8  write data, latched on acceptance.
REQ-010 cpu_rdata  output  8  registered read data, valid while cpu_ack high.
REQ-011 cpu_ack  output  1  one-cycle completion pulse.
REQ-012 rom_oe / rom_addr / rom_data  output 1 / output 15 / input 8  ROM read port; rom_data is high-Z when rom_oe is low.
REQ-013 ram_cs / ram_we / ram_addr / ram_wdata / ram_rdata  output 1 / output 1 / output 15 / output 8 / input 8  RAM port.
REQ-014 io_cs / io_we / io_addr / io_wdata / io_rdata  output 1 / output 1 / output 4 / output 8 / input 8  IO register port.
REQ-015 rom_wr_err  output  1  sticky flag: a write targeted ROM.

Function
REQ-016 Decode from latched address SHALL be: 0x0000-0x5FFF RAM; 0x6000-0x7FFF IO; 0x8000-0xFFFF ROM.
REQ-017 rom_addr SHALL be {2'b00, addr[12:0]}, so the 8 KiB ROM mirrors four times and 0xFFFC maps to 0x1FFC.
REQ-018 ram_addr SHALL be addr[14:0]; io_addr SHALL be addr[3:0], giving 16 IO registers mirrored across the IO window.
REQ-019 FSM states SHALL be IDLE, ACCESS and DONE; reset state is IDLE.
REQ-020 IDLE with cpu_req=1 at edge N SHALL latch addr/rw/wdata, load the wait counter with the region's WAIT value, and enter ACCESS at N+1.
REQ-021 In ACCESS, the selected region's select (rom_oe, ram_cs, io_cs) SHALL be high; all other selects SHALL be low.
REQ-022 ACCESS SHALL last exactly WAIT+1 cycles, then the FSM SHALL enter DONE.
REQ-023 On the final ACCESS cycle of a read, the selected region's data SHALL be registered into cpu_rdata.
REQ-024 ram_we/io_we SHALL be high only on the final ACCESS cycle of a write; ram_wdata/io_wdata SHALL carry latched wdata throughout ACCESS.
REQ-025 A write to ROM SHALL keep rom_oe low, set rom_wr_err, and still complete with cpu_ack.
REQ-026 DONE SHALL assert cpu_ack for exactly one cycle with all selects low, then return to IDLE.
REQ-027 cpu_req in ACCESS or DONE SHALL be ignored; back-to-back requests SHALL complete one access every WAIT+3 cycles.
REQ-028 Read latency from acceptance edge to cpu_ack SHALL be WAIT+2 cycles.
REQ-029 cpu_rdata SHALL hold its value until the next read completes; writes SHALL not modify it.

Reset
REQ-030 Reset SHALL apply the following on the next edge, including mid-access: state IDLE; cpu_ack, all selects and write enables 0; cpu_rdata 0x00; rom_wr_err 0; wait counter 0.
REQ-031 An access interrupted by reset SHALL produce no cpu_ack and no write strobe.
REQ-032 reset SHALL have priority over cpu_req in the same cycle.

Structure
REQ-033 A shared package mem_map_pkg SHALL hold the region enum (REG_RAM, REG_IO, REG_ROM), the region base and limit constants, and the FSM state enum.
REQ-034 The wait-state down-counter SHALL be a sub-module, wait_counter (3-bit, load/decrement/zero flag).

Verification
REQ-035 ROM read at 0xFFFC with ROM_WAIT=1, rom_data=0x00 -> rom_addr=0x1FFC, rom_oe high 2 cycles, cpu_ack 3 cycles after acceptance, cpu_rdata=0x00.
REQ-036 RAM write 0x1234 <- 0xA5 with RAM_WAIT=0 -> ram_cs high 1 cycle, ram_we high in that same cycle, ram_wdata=0xA5, ack at +2.
REQ-037 IO read at 0x7FF3 with IO_WAIT=2 -> io_addr=0x3, io_cs high 3 cycles, ack at +4, cpu_rdata=io_rdata.
REQ-038 Write to 0x9000 -> rom_oe never high, rom_wr_err=1 and it stays 1 after a later RAM access, ack still pulses.
REQ-039 Reset asserted on the second ACCESS cycle of an IO read -> next cycle all selects 0, no cpu_ack, state IDLE.
REQ-040 cpu_req held high for 20 cycles with RAM_WAIT=0 -> exactly one access every 3 cycles, cpu_ack never on consecutive cycles.
